config_reg_read_port: RTL and testbench

- Read-side responder for a bank of configuration registers. The write side is a plain enable/data register write.
- Serves address-based read requests over a valid/ready handshake and returns data through a 2-entry response buffer.
- Sits between the CSR/debug access path and core configuration state, so config state can be sampled without stalling the writer.
- Reads follow ConfigReg semantics: a same-cycle write is never visible to a read.

---
 rtl/config_reg_read_port_if.sv | 32 +++
 rtl/config_reg_read_port.sv | 145 ++++++++++++++
 tb/tb_config_reg_read_port.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/config_reg_read_port_if.sv
// Config register port bundle: plain write strobe, valid/ready read request/response, flat register view.
interface config_reg_read_port_if #(
    parameter int unsigned width  = 32,
    parameter int unsigned nregs  = 8,
    parameter int unsigned awidth = 3
) ();

    logic                    wr_en;
    logic [awidth-1:0]       wr_addr;
    logic [width-1:0]        wr_data;
    logic                    req_valid;
    logic                    req_ready;
    logic [awidth-1:0]       req_addr;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [width-1:0]        rsp_data;
    logic                    rsp_err;
    logic [nregs*width-1:0]  q_all;

    // Requester / writer side
    modport master (
        output wr_en, wr_addr, wr_data, req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, q_all
    );

    // Register bank side
    modport slave (
        input  wr_en, wr_addr, wr_data, req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, q_all
    );

endinterface

// File: rtl/config_reg_read_port.sv
// Config register bank with a read responder; reads see pre-write values, responses go through a 2-entry buffer.
module config_reg_read_port #(
    parameter int unsigned width  = 32,
    parameter int unsigned nregs  = 8,
    parameter int unsigned awidth = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    config_reg_read_port_if.slave bus
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    // Register count must fit the address space
    if (nregs < 1 || nregs > (32'd1 << awidth)) begin : g_bad_nregs
        $error("config_reg_read_port: nregs does not fit in awidth address bits");
    end

    logic [width-1:0]       regs [nregs];
    logic [1:0]             state, state_nxt;
    logic [width-1:0]       head_data, head_data_nxt;
    logic                   head_err, head_err_nxt;
    logic [width-1:0]       tail_data, tail_data_nxt;
    logic                   tail_err, tail_err_nxt;
    logic                   req_ready_q, req_ready_nxt;
    logic                   rsp_valid_q, rsp_valid_nxt;
    logic                   fire, deq;
    logic [width-1:0]       rd_data;
    logic                   rd_err;
    logic [nregs*width-1:0] q_all_w;

    assign fire = bus.req_valid && req_ready_q;
    assign deq  = rsp_valid_q && bus.rsp_ready;

    // Read lookup on current register contents; unmatched address is an error with zero data
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int unsigned i = 0; i < nregs; i++) begin
            if (bus.req_addr == awidth'(i)) begin
                rd_data = regs[i];
                rd_err  = 1'b0;
            end
        end
    end

    // Register bank write; out-of-range addresses match nothing and are dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < nregs; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wr_en) begin
            for (int unsigned i = 0; i < nregs; i++) begin
                if (bus.wr_addr == awidth'(i)) begin
                    regs[i] <= bus.wr_data;
                end
            end
        end
    end

    // Flat view of all registers
    always_comb begin
        q_all_w = '0;
        for (int unsigned i = 0; i < nregs; i++) begin
            q_all_w[i*width +: width] = regs[i];
        end
    end

    // Response buffer next state: head drives the outputs, tail holds the second entry
    always_comb begin
        state_nxt     = state;
        head_data_nxt = head_data;
        head_err_nxt  = head_err;
        tail_data_nxt = tail_data;
        tail_err_nxt  = tail_err;
        case (state)
            S_EMPTY: begin
                if (fire) begin
                    state_nxt     = S_ONE;
                    head_data_nxt = rd_data;
                    head_err_nxt  = rd_err;
                end
            end
            S_ONE: begin
                if (fire && !deq) begin
                    state_nxt     = S_TWO;
                    tail_data_nxt = rd_data;
                    tail_err_nxt  = rd_err;
                end else if (fire && deq) begin
                    head_data_nxt = rd_data;
                    head_err_nxt  = rd_err;
                end else if (deq) begin
                    state_nxt     = S_EMPTY;
                    head_data_nxt = '0;
                    head_err_nxt  = 1'b0;
                end
            end
            S_TWO: begin
                if (deq) begin
                    state_nxt     = S_ONE;
                    head_data_nxt = tail_data;
                    head_err_nxt  = tail_err;
                end
            end
            default: begin
                state_nxt     = S_EMPTY;
                head_data_nxt = '0;
                head_err_nxt  = 1'b0;
            end
        endcase
        req_ready_nxt = (state_nxt != S_TWO);
        rsp_valid_nxt = (state_nxt != S_EMPTY);
    end

    // Response buffer state and registered handshake outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_EMPTY;
            head_data   <= '0;
            head_err    <= 1'b0;
            tail_data   <= '0;
            tail_err    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            head_data   <= head_data_nxt;
            head_err    <= head_err_nxt;
            tail_data   <= tail_data_nxt;
            tail_err    <= tail_err_nxt;
            req_ready_q <= req_ready_nxt;
            rsp_valid_q <= rsp_valid_nxt;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = head_data;
    assign bus.rsp_err   = head_err;
    assign bus.q_all     = q_all_w;

endmodule

// File: tb/tb_config_reg_read_port.sv
// Bench for config_reg_read_port: directed scenarios plus random traffic against a queue-based model.
module tb_config_reg_read_port;

    logic CLK;
    logic RST_N;

    config_reg_read_port_if #(.width(32), .nregs(8), .awidth(4)) bus ();

    config_reg_read_port #(.width(32), .nregs(8), .awidth(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Model: register array plus an ordered queue of pending {err, data} responses, capacity 2
    logic [31:0] mregs [8];
    logic [32:0] exp_q [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [255:0] model_q_all();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = mregs[i];
        return v;
    endfunction

    function automatic logic [32:0] model_read();
        if (bus.req_addr < 4'd8) return {1'b0, mregs[bus.req_addr[2:0]]};
        return {1'b1, 32'h0};
    endfunction

    // Model update: dequeue/enqueue decided on pre-edge occupancy, read sees pre-write registers
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) mregs[i] <= '0;
        end else begin
            if (bus.rsp_ready && exp_q.size() != 0) begin
                if (bus.req_valid && exp_q.size() < 2) exp_q.push_back(model_read());
                void'(exp_q.pop_front());
            end else if (bus.req_valid && exp_q.size() < 2) begin
                exp_q.push_back(model_read());
            end
            if (bus.wr_en && bus.wr_addr < 4'd8) mregs[bus.wr_addr[2:0]] <= bus.wr_data;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            chk("rsp_valid", 256'(bus.rsp_valid), 256'(exp_q.size() != 0));
            chk("req_ready", 256'(bus.req_ready), 256'(exp_q.size() < 2));
            if (exp_q.size() != 0) begin
                chk("rsp_data", 256'(bus.rsp_data), 256'(exp_q[0][31:0]));
                chk("rsp_err", 256'(bus.rsp_err), 256'(exp_q[0][32]));
            end
            chk("q_all", bus.q_all, model_q_all());
        end
    end

    logic [255:0] lit_q;

    initial begin
        RST_N         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset rsp_valid", 256'(bus.rsp_valid), 256'(0));
        chk("reset req_ready", 256'(bus.req_ready), 256'(1));
        chk("reset rsp_data", 256'(bus.rsp_data), 256'(0));
        chk("reset rsp_err", 256'(bus.rsp_err), 256'(0));
        chk("reset q_all", bus.q_all, 256'(0));
        RST_N = 1'b1;

        // Back-to-back reads of every register
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 4'(i);
            @(negedge CLK);
            if (i == 0) begin
                chk("first rsp latency", 256'(bus.rsp_valid), 256'(1));
                chk("first rsp data", 256'(bus.rsp_data), 256'(0));
            end
        end
        bus.req_valid = 1'b0;
        @(negedge CLK);

        // Same-cycle write and read returns old value
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 4'd3;
        bus.wr_data   = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd3;
        @(negedge CLK);
        bus.wr_en = 1'b0;
        chk("rd during wr old", 256'(bus.rsp_data), 256'(0));
        @(negedge CLK);
        chk("rd after wr new", 256'(bus.rsp_data), 256'(32'hDEADBEEF));
        chk("q_all reg3", 256'(bus.q_all[127:96]), 256'(32'hDEADBEEF));
        bus.req_valid = 1'b0;
        @(negedge CLK);

        // Backpressure: fill the buffer, hold, then drain in order
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd1;
        bus.wr_data = 32'h11;
        @(negedge CLK);
        bus.wr_addr = 4'd2;
        bus.wr_data = 32'h22;
        @(negedge CLK);
        bus.wr_en     = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd1;
        @(negedge CLK);
        bus.req_addr = 4'd2;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        chk("full req_ready", 256'(bus.req_ready), 256'(0));
        chk("full head", 256'(bus.rsp_data), 256'(32'h11));
        @(negedge CLK);
        chk("stall head stable", 256'(bus.rsp_data), 256'(32'h11));
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        chk("second rsp", 256'(bus.rsp_data), 256'(32'h22));
        chk("ready after deq", 256'(bus.req_ready), 256'(1));
        @(negedge CLK);
        chk("drained", 256'(bus.rsp_valid), 256'(0));

        // Out-of-range read and write
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd9;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        chk("oor err", 256'(bus.rsp_err), 256'(1));
        chk("oor data", 256'(bus.rsp_data), 256'(0));
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd9;
        bus.wr_data = 32'h5;
        @(negedge CLK);
        bus.wr_en = 1'b0;
        @(negedge CLK);
        lit_q = '0;
        lit_q[63:32]  = 32'h11;
        lit_q[95:64]  = 32'h22;
        lit_q[127:96] = 32'hDEADBEEF;
        chk("oor write ignored", bus.q_all, lit_q);

        // Reset with a full buffer
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd2;
        @(negedge CLK);
        bus.req_addr = 4'd3;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        chk("prefill full", 256'(bus.req_ready), 256'(0));
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async rst rsp_valid", 256'(bus.rsp_valid), 256'(0));
        chk("async rst req_ready", 256'(bus.req_ready), 256'(1));
        chk("async rst q_all", bus.q_all, 256'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge CLK);
        chk("no stale rsp", 256'(bus.rsp_valid), 256'(0));

        // Random interleave of writes, requests and consumer backpressure
        for (int i = 0; i < 10000; i++) begin
            bus.wr_en     = ($urandom_range(0, 3) == 0);
            bus.wr_addr   = 4'($urandom_range(0, 15));
            bus.wr_data   = $urandom;
            bus.req_valid = ($urandom_range(0, 2) != 0);
            bus.req_addr  = 4'($urandom_range(0, 9));
            bus.rsp_ready = ((i % 1000) < 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge CLK);
        end
        bus.wr_en     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(negedge CLK);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
